// File: rtl/beamformer_pkg.sv
// Shared beamformer types and default sizing.
package beamformer_pkg;

  localparam int NUMBER_OF_BITS = 8;
  localparam int BUFFER_SIZE    = 16;
  localparam int NUM_CHANNELS   = 2;
  localparam int CH_LOG2        = $clog2(NUM_CHANNELS);
  localparam int SUM_BITS       = NUMBER_OF_BITS + CH_LOG2;

  typedef logic signed [NUMBER_OF_BITS-1:0] pcm_t;
  typedef logic signed [SUM_BITS-1:0]       sum_t;

endpackage

// File: rtl/i2s_word_serializer.sv
// I2S slot timing: half-frame position counter, word select and registered
// serial data (slot 0 is the delay bit, slots 1..N carry the word MSB-first).
module i2s_word_serializer #(
  parameter int NUMBER_OF_BITS = 8,
  parameter int WS_HALF_PERIOD = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic [NUMBER_OF_BITS-1:0] load_word,
  output logic                      load_req,
  output logic                      ws_out,
  output logic                      sd_out
);
  import beamformer_pkg::*;

  localparam int PW = (WS_HALF_PERIOD > 2) ? $clog2(WS_HALF_PERIOD) : 1;
  localparam logic [PW-1:0] POS_LAST = PW'(WS_HALF_PERIOD - 1);

  logic [PW-1:0]             pos_r;
  logic [NUMBER_OF_BITS-1:0] shift_r;
  logic                      ws_r;
  logic                      sd_r;
  logic                      sd_next_s;

  assign load_req = ena & (pos_r == {PW{1'b0}});
  assign ws_out   = ws_r;
  assign sd_out   = sd_r;

  // Bit presented for the current slot; it reaches sd_out one cycle later.
  always_comb begin
    sd_next_s = 1'b0;
    if ((int'(pos_r) >= 1) && (int'(pos_r) <= NUMBER_OF_BITS)) begin
      sd_next_s = shift_r[NUMBER_OF_BITS-1];
    end else begin
      sd_next_s = 1'b0;
    end
  end

  // Position counter, word select and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_r   <= {PW{1'b0}};
      ws_r    <= 1'b0;
      shift_r <= {NUMBER_OF_BITS{1'b0}};
      sd_r    <= 1'b0;
    end else if (!ena) begin
      pos_r   <= {PW{1'b0}};
      ws_r    <= 1'b0;
      shift_r <= {NUMBER_OF_BITS{1'b0}};
      sd_r    <= 1'b0;
    end else begin
      sd_r <= sd_next_s;
      if (pos_r == {PW{1'b0}}) begin
        shift_r <= load_word;
      end else begin
        shift_r <= {shift_r[NUMBER_OF_BITS-2:0], 1'b0};
      end
      if (pos_r == POS_LAST) begin
        pos_r <= {PW{1'b0}};
        ws_r  <= ~ws_r;
      end else begin
        pos_r <= pos_r + {{(PW-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/beam_sum_i2s_tx.sv
// Beam combiner and mono I2S transmitter. Build option: BEAM_SATURATE_EN
// selects a clamped sum; otherwise the truncated channel average is sent.
module beam_sum_i2s_tx #(
  parameter int NUMBER_OF_BITS = beamformer_pkg::NUMBER_OF_BITS,
  parameter int NUM_CHANNELS   = beamformer_pkg::NUM_CHANNELS,
  parameter int WS_HALF_PERIOD = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   ena,
  input  logic [NUM_CHANNELS*NUMBER_OF_BITS-1:0] ch_data,
  input  logic                                   sample_valid,
  output logic                                   sample_ready,
  output logic                                   sd_out,
  output logic                                   ws_out,
  output logic                                   frame_start,
  output logic                                   underrun
);
  import beamformer_pkg::*;

  localparam int LOG2C = $clog2(NUM_CHANNELS);
  localparam int SW    = NUMBER_OF_BITS + LOG2C;

`ifdef BEAM_SATURATE_EN
  localparam logic signed [SW-1:0] SUM_MAX = {{(LOG2C+1){1'b0}}, {(NUMBER_OF_BITS-1){1'b1}}};
  localparam logic signed [SW-1:0] SUM_MIN = {{(LOG2C+1){1'b1}}, {(NUMBER_OF_BITS-1){1'b0}}};
  localparam logic [NUMBER_OF_BITS-1:0] PCM_MAX = {1'b0, {(NUMBER_OF_BITS-1){1'b1}}};
  localparam logic [NUMBER_OF_BITS-1:0] PCM_MIN = {1'b1, {(NUMBER_OF_BITS-1){1'b0}}};
`endif

  logic signed [SW-1:0]      sum_s;
  logic [NUMBER_OF_BITS-1:0] beam_s;
  logic [NUMBER_OF_BITS-1:0] hold_r;
  logic                      hold_full_r;
  logic [NUMBER_OF_BITS-1:0] latched_r;
  logic                      frame_start_r;
  logic                      underrun_r;
  logic [NUMBER_OF_BITS-1:0] load_word_s;
  logic                      load_req_s;
  logic                      ws_s;
  logic                      accept_s;
  logic                      load_left_s;

  assign sample_ready = ~hold_full_r & ena;
  assign accept_s     = sample_valid & sample_ready;
  assign load_left_s  = load_req_s & ~ws_s;
  assign ws_out       = ws_s;
  assign frame_start  = frame_start_r;
  assign underrun     = underrun_r;

  // Sign-extended sum of all channels.
  always_comb begin
    sum_s = {SW{1'b0}};
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      sum_s = sum_s + {{LOG2C{ch_data[i*NUMBER_OF_BITS + NUMBER_OF_BITS - 1]}},
                       ch_data[i*NUMBER_OF_BITS +: NUMBER_OF_BITS]};
    end
  end

  // Reduce the wide sum back to one PCM word.
  always_comb begin
    beam_s = {NUMBER_OF_BITS{1'b0}};
`ifdef BEAM_SATURATE_EN
    if (sum_s > SUM_MAX) begin
      beam_s = PCM_MAX;
    end else if (sum_s < SUM_MIN) begin
      beam_s = PCM_MIN;
    end else begin
      beam_s = sum_s[NUMBER_OF_BITS-1:0];
    end
`else
    beam_s = NUMBER_OF_BITS'(sum_s >>> LOG2C);
`endif
  end

  // Word handed to the serializer at slot 0: fresh sample on the left, repeat on the right.
  always_comb begin
    load_word_s = {NUMBER_OF_BITS{1'b0}};
    if (ws_s) begin
      load_word_s = latched_r;
    end else if (hold_full_r) begin
      load_word_s = hold_r;
    end else begin
      load_word_s = {NUMBER_OF_BITS{1'b0}};
    end
  end

  // Holding register, per-frame latched word and frame pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_r        <= {NUMBER_OF_BITS{1'b0}};
      hold_full_r   <= 1'b0;
      latched_r     <= {NUMBER_OF_BITS{1'b0}};
      frame_start_r <= 1'b0;
      underrun_r    <= 1'b0;
    end else if (!ena) begin
      hold_r        <= {NUMBER_OF_BITS{1'b0}};
      hold_full_r   <= 1'b0;
      latched_r     <= {NUMBER_OF_BITS{1'b0}};
      frame_start_r <= 1'b0;
      underrun_r    <= 1'b0;
    end else begin
      frame_start_r <= load_left_s;
      underrun_r    <= load_left_s & ~hold_full_r;
      // An accept on the frame-start edge only fills the holder for the next frame.
      if (accept_s) begin
        hold_r      <= beam_s;
        hold_full_r <= 1'b1;
      end else if (load_left_s) begin
        hold_full_r <= 1'b0;
      end
      if (load_left_s) begin
        latched_r <= load_word_s;
      end
    end
  end

  i2s_word_serializer #(
    .NUMBER_OF_BITS (NUMBER_OF_BITS),
    .WS_HALF_PERIOD (WS_HALF_PERIOD)
  ) u_serializer (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .load_word (load_word_s),
    .load_req  (load_req_s),
    .ws_out    (ws_s),
    .sd_out    (sd_out)
  );

endmodule

// File: tb/tb_beam_sum_i2s_tx.sv
// Self-checking bench for beam_sum_i2s_tx: frame-level reference model plus directed literals.
module tb_beam_sum_i2s_tx;
  import beamformer_pkg::*;

  localparam int N = 8;
  localparam int C = 2;
  localparam int H = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ena = 1'b1;
  logic [C*N-1:0]   ch_data = '0;
  logic             sample_valid = 1'b0;
  logic             sample_ready;
  logic             sd_out;
  logic             ws_out;
  logic             frame_start;
  logic             underrun;

  int total = 0;
  int bad = 0;

  beam_sum_i2s_tx #(.NUMBER_OF_BITS(N), .NUM_CHANNELS(C), .WS_HALF_PERIOD(H)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ch_data(ch_data),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sd_out(sd_out), .ws_out(ws_out), .frame_start(frame_start), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Beam value straight from the arithmetic definition.
  function automatic pcm_t combine(input logic [C*N-1:0] d);
    int s;
    s = 0;
    for (int i = 0; i < C; i++) s += int'($signed(d[i*N +: N]));
`ifdef BEAM_SATURATE_EN
    if (s > 127) s = 127;
    else if (s < -128) s = -128;
`else
    if (s >= 0) s = s / C;
    else s = -((-s + C - 1) / C);
`endif
    return pcm_t'(s);
  endfunction

  // Reference model: m_k is the cycle index since the last restart.
  int         m_k = 0;
  bit         m_full = 0;
  logic [7:0] m_val = '0;
  logic [7:0] m_word = '0;
  logic       e_sd = 0, e_ws = 0, e_fs = 0, e_ur = 0;
  int         m_p;
  bit         m_left0, m_acc;

  initial forever begin
    @(posedge clk);
    if (!rst_n || !ena) begin
      m_k = 0; m_full = 0; m_val = '0; m_word = '0;
      e_sd = 0; e_ws = 0; e_fs = 0; e_ur = 0;
    end else begin
      m_p     = m_k % H;
      m_left0 = (m_k % (2*H)) == 0;
      m_acc   = sample_valid && !m_full;
      e_fs    = m_left0;
      e_ur    = m_left0 && !m_full;
      if (m_left0) begin
        m_word = m_full ? m_val : 8'h00;
        m_full = 0;
      end
      if (m_acc) begin
        m_full = 1;
        m_val  = combine(ch_data);
      end
      e_sd = (m_p >= 1 && m_p <= N) ? m_word[N - m_p] : 1'b0;
      m_k++;
      e_ws = ((m_k / H) % 2) == 1;
    end
  end

  // Every-cycle compare against the model, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    chk("sd_out",       {31'd0, sd_out},       {31'd0, rst_n ? e_sd : 1'b0});
    chk("ws_out",       {31'd0, ws_out},       {31'd0, rst_n ? e_ws : 1'b0});
    chk("frame_start",  {31'd0, frame_start},  {31'd0, rst_n ? e_fs : 1'b0});
    chk("underrun",     {31'd0, underrun},     {31'd0, rst_n ? e_ur : 1'b0});
    chk("sample_ready", {31'd0, sample_ready}, {31'd0, ena && (!rst_n || !m_full)});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [C*N-1:0] d);
    int g;
    g = 0;
    while (!sample_ready && g < 200) begin step(); g++; end
    chk("send_wait", {31'd0, sample_ready}, 32'd1);
    sample_valid = 1'b1;
    ch_data = d;
    step();
    sample_valid = 1'b0;
  endtask

  // Collect left and right words from the next non-underrun frame.
  task automatic capture(output logic [7:0] lw, output logic [7:0] rw);
    bit ok;
    int g;
    ok = 0; g = 0; lw = '0; rw = '0;
    while (!ok && g < 400) begin
      @(negedge clk);
      g++;
      if (frame_start && !underrun) ok = 1;
    end
    chk("capture_found", {31'd0, ok}, 32'd1);
    for (int c = 1; c < 2*H; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= N) lw = {lw[6:0], sd_out};
      if (c >= H+1 && c <= H+N) rw = {rw[6:0], sd_out};
    end
  endtask

  task automatic directed(input string name, input logic [C*N-1:0] d, input logic [7:0] exp);
    logic [7:0] lw, rw;
    send_one(d);
    capture(lw, rw);
    chk({name, "_left"},  {24'd0, lw}, {24'd0, exp});
    chk({name, "_right"}, {24'd0, rw}, {24'd0, exp});
  endtask

  task automatic wait_right4();
    int g;
    g = 0;
    while ((m_k % (2*H)) != H + 4 && g < 200) begin
      sample_valid = 1'b1;
      ch_data = C*N'($urandom);
      step();
      g++;
    end
    chk("wait_pos4", m_k % (2*H), H + 4);
  endtask

  initial begin
    int urc, sdc;
    logic [7:0] lw, rw;

    repeat (3) step();
    @(negedge clk);
    chk("rst_sd", {31'd0, sd_out}, 32'd0);
    chk("rst_ws", {31'd0, ws_out}, 32'd0);
    chk("rst_fs", {31'd0, frame_start}, 32'd0);
    chk("rst_ur", {31'd0, underrun}, 32'd0);
    chk("rst_ready", {31'd0, sample_ready}, 32'd1);
    step();
    rst_n = 1'b1;

`ifdef BEAM_SATURATE_EN
    directed("sum_10_20", {8'h10, 8'h20}, 8'h30);
    directed("sat_pos",   {8'h70, 8'h70}, 8'h7F);
    directed("sat_neg",   {8'h80, 8'hF0}, 8'h80);
    directed("sum_80_ff", {8'h80, 8'hFF}, 8'h80);
`else
    directed("avg_10_20", {8'h10, 8'h20}, 8'h18);
    directed("avg_80_ff", {8'h80, 8'hFF}, 8'hBF);
    directed("avg_70_70", {8'h70, 8'h70}, 8'h70);
    directed("avg_80_f0", {8'h80, 8'hF0}, 8'hB8);
`endif

    // Two idle frames: one underrun per frame, silent data.
    begin
      int g;
      g = 0;
      while (!(frame_start && underrun) && g < 200) begin @(negedge clk); g++; end
      chk("idle_find", {31'd0, frame_start && underrun}, 32'd1);
      urc = 0; sdc = 0;
      for (int c = 0; c < 4*H; c++) begin
        @(negedge clk);
        if (underrun) urc++;
        if (sd_out) sdc++;
      end
      chk("idle_underruns", urc, 2);
      chk("idle_sd_ones", sdc, 0);
    end

    // Accept on the very first frame-start edge after reset.
    step();
    rst_n = 1'b0;
    sample_valid = 1'b1;
    ch_data = {8'h40, 8'h20};
    step();
    rst_n = 1'b1;
    step();
    sample_valid = 1'b0;
    @(negedge clk);
    chk("bnd_fs", {31'd0, frame_start}, 32'd1);
    chk("bnd_ur", {31'd0, underrun}, 32'd1);
    capture(lw, rw);
`ifdef BEAM_SATURATE_EN
    chk("bnd_word", {24'd0, lw}, 32'h60);
`else
    chk("bnd_word", {24'd0, lw}, 32'h30);
`endif

    // Back-to-back offers with fresh data every cycle.
    step();
    for (int c = 0; c < 12*H; c++) begin
      sample_valid = 1'b1;
      ch_data = C*N'($urandom);
      step();
    end

    // Reset asserted mid-word in the right half.
    wait_right4();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sd", {31'd0, sd_out}, 32'd0);
    chk("mid_rst_ws", {31'd0, ws_out}, 32'd0);
    sample_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    @(negedge clk);
    chk("rst_rel_fs", {31'd0, frame_start}, 32'd1);
    chk("rst_rel_ur", {31'd0, underrun}, 32'd1);

    // Enable dropped mid-word in the right half.
    wait_right4();
    ena = 1'b0;
    sample_valid = 1'b0;
    step();
    @(negedge clk);
    chk("ena_low_sd", {31'd0, sd_out}, 32'd0);
    chk("ena_low_ws", {31'd0, ws_out}, 32'd0);
    step();
    ena = 1'b1;
    step();
    @(negedge clk);
    chk("ena_rel_fs", {31'd0, frame_start}, 32'd1);
    chk("ena_rel_ur", {31'd0, underrun}, 32'd1);

    // Random traffic with occasional enable drops.
    for (int c = 0; c < 3000; c++) begin
      sample_valid = ($urandom_range(0, 3) != 0);
      ch_data = C*N'($urandom);
      ena = ($urandom_range(0, 199) != 0) ? 1'b1 : ~ena;
      step();
    end
    ena = 1'b1;
    repeat (4*H) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
